// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared bus command codes, default widths and unit state type
package mem_bus_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 9;
    localparam int REGION_BIT = DEF_ADDR_W - 1;

    localparam logic [1:0] MNONE  = 2'b01;
    localparam logic [1:0] MREAD  = 2'b00;
    localparam logic [1:0] MWRITE = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR,
        ST_IO_WAIT
    } state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response and memory bus signals of the access unit
interface mem_access_unit_if
    import mem_bus_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              io_ready;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, read_data, io_ready,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_cmd, mem_addr, write_data
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, read_data, io_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_cmd, mem_addr, write_data
    );

endinterface

// File: rtl/io_wait_timer.sv
// rtl/io_wait_timer.sv - clearable wait-cycle counter flagging the last allowed I/O cycle
module io_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic timeout
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign timeout = (count_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !timeout) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-outstanding load/store initiator for the RAM and I/O bus
module mem_access_unit
    import mem_bus_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    mem_access_unit_if.master   bus
);
    state_e            state_q, state_d;
    logic              write_q, write_d;
    logic [1:0]        mem_cmd_q, mem_cmd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              timer_clear, timer_en, timer_timeout;

    io_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (reset),
        .clear   (timer_clear),
        .enable  (timer_en),
        .timeout (timer_timeout)
    );

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.mem_cmd    = mem_cmd_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.write_data = write_data_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        mem_cmd_d    = mem_cmd_q;
        mem_addr_d   = mem_addr_q;
        write_data_d = write_data_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = 1'b0;
        timer_clear  = 1'b0;
        timer_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    write_d      = bus.req_write;
                    mem_addr_d   = bus.req_addr;
                    write_data_d = bus.req_wdata;
                    timer_clear  = 1'b1;
                    if (bus.req_addr[REGION_BIT]) begin
                        state_d   = ST_IO_WAIT;
                        mem_cmd_d = bus.req_write ? MWRITE : MREAD;
                    end else if (bus.req_write) begin
                        state_d   = ST_WR;
                        mem_cmd_d = MWRITE;
                    end else begin
                        state_d   = ST_RD_ADDR;
                        mem_cmd_d = MREAD;
                    end
                end
            end
            ST_RD_ADDR: state_d = ST_RD_DATA;
            // RAM dout became valid after the RD_ADDR edge; keep MREAD so it stays on the bus
            ST_RD_DATA: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = bus.read_data;
                mem_cmd_d    = MNONE;
                state_d      = ST_IDLE;
            end
            ST_WR: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = '0;
                mem_cmd_d    = MNONE;
                state_d      = ST_IDLE;
            end
            ST_IO_WAIT: begin
                timer_en = 1'b1;
                if (bus.io_ready) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = write_q ? '0 : bus.read_data;
                    mem_cmd_d    = MNONE;
                    state_d      = ST_IDLE;
                end else if (timer_timeout) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = '0;
                    mem_cmd_d    = MNONE;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                mem_cmd_d = MNONE;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            write_q      <= 1'b0;
            mem_cmd_q    <= MNONE;
            mem_addr_q   <= '0;
            write_data_q <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            mem_cmd_q    <= mem_cmd_d;
            mem_addr_q   <= mem_addr_d;
            write_data_q <= write_data_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic [15:0] io_rdata;
    logic [15:0] ram_dout;
    logic [15:0] ram [0:255];
    int          n_tests;
    int          n_fail;

    mem_access_unit_if #(.DATA_W(16), .ADDR_W(9)) bus ();

    mem_access_unit #(.DATA_W(16), .ADDR_W(9), .TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM on the low half of the address space
    always @(posedge clk) begin
        if (bus.mem_cmd == 2'b10 && !bus.mem_addr[8]) ram[bus.mem_addr[7:0]] <= bus.write_data;
        if (bus.mem_cmd == 2'b00 && !bus.mem_addr[8]) ram_dout <= ram[bus.mem_addr[7:0]];
    end

    assign bus.read_data = (bus.mem_cmd == 2'b00) ? (bus.mem_addr[8] ? io_rdata : ram_dout) : 16'hzzzz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic put_req(input logic wr, input logic [8:0] addr, input logic [15:0] wdata);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
    endtask

    task automatic store_ram(input logic [8:0] addr, input logic [15:0] wdata);
        put_req(1'b1, addr, wdata);
        step();
        bus.req_valid = 1'b0;
        step();
        chk("prep_store_ack", {31'd0, bus.resp_valid}, 32'd1);
        step();
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.io_ready  = 1'b0;
        io_rdata      = 16'h0;
        #3;
        chk("rst_mem_cmd", {30'd0, bus.mem_cmd}, 32'h1);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_mem_addr", {23'd0, bus.mem_addr}, 32'h0);
        chk("rst_resp_rdata", {16'd0, bus.resp_rdata}, 32'h0);
        chk("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
        step();
        step();
        reset = 1'b0;
        step();
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

        // Store 00A5 -> 012
        put_req(1'b1, 9'h012, 16'h00A5);
        step();
        bus.req_valid = 1'b0;
        chk("st_cmd_c1", {30'd0, bus.mem_cmd}, 32'h2);
        chk("st_addr_c1", {23'd0, bus.mem_addr}, 32'h012);
        chk("st_wdata_c1", {16'd0, bus.write_data}, 32'h00A5);
        chk("st_ready_c1", {31'd0, bus.req_ready}, 32'd0);
        chk("st_rv_c1", {31'd0, bus.resp_valid}, 32'd0);
        step();
        chk("st_rv_c2", {31'd0, bus.resp_valid}, 32'd1);
        chk("st_rdata_c2", {16'd0, bus.resp_rdata}, 32'h0);
        chk("st_err_c2", {31'd0, bus.resp_err}, 32'd0);
        chk("st_cmd_c2", {30'd0, bus.mem_cmd}, 32'h1);
        step();
        chk("st_rv_c3", {31'd0, bus.resp_valid}, 32'd0);

        // Load 012
        put_req(1'b0, 9'h012, 16'h0);
        chk("ld_cmd_c0", {30'd0, bus.mem_cmd}, 32'h1);
        step();
        bus.req_valid = 1'b0;
        chk("ld_cmd_c1", {30'd0, bus.mem_cmd}, 32'h0);
        chk("ld_rv_c1", {31'd0, bus.resp_valid}, 32'd0);
        step();
        chk("ld_cmd_c2", {30'd0, bus.mem_cmd}, 32'h0);
        chk("ld_addr_c2", {23'd0, bus.mem_addr}, 32'h012);
        chk("ld_rv_c2", {31'd0, bus.resp_valid}, 32'd0);
        step();
        chk("ld_rv_c3", {31'd0, bus.resp_valid}, 32'd1);
        chk("ld_rdata_c3", {16'd0, bus.resp_rdata}, 32'h00A5);
        chk("ld_cmd_c3", {30'd0, bus.mem_cmd}, 32'h1);
        chk("ld_ready_c3", {31'd0, bus.req_ready}, 32'd1);
        step();

        // Back-to-back loads of 003 and 004
        store_ram(9'h003, 16'h1111);
        store_ram(9'h004, 16'h2222);
        put_req(1'b0, 9'h003, 16'h0);
        step();
        bus.req_addr = 9'h004;
        step();
        step();
        chk("b2b_rv1", {31'd0, bus.resp_valid}, 32'd1);
        chk("b2b_rdata1", {16'd0, bus.resp_rdata}, 32'h1111);
        chk("b2b_ready1", {31'd0, bus.req_ready}, 32'd1);
        step();
        bus.req_valid = 1'b0;
        chk("b2b_rv_gap", {31'd0, bus.resp_valid}, 32'd0);
        chk("b2b_cmd2", {30'd0, bus.mem_cmd}, 32'h0);
        chk("b2b_addr2", {23'd0, bus.mem_addr}, 32'h004);
        step();
        chk("b2b_rv_gap2", {31'd0, bus.resp_valid}, 32'd0);
        step();
        chk("b2b_rv2", {31'd0, bus.resp_valid}, 32'd1);
        chk("b2b_rdata2", {16'd0, bus.resp_rdata}, 32'h2222);
        step();
        chk("b2b_rv_after", {31'd0, bus.resp_valid}, 32'd0);

        // I/O load 100, io_ready in the 4th wait cycle
        put_req(1'b0, 9'h100, 16'h0);
        step();
        bus.req_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            chk("io_ld_cmd_wait", {30'd0, bus.mem_cmd}, 32'h0);
            chk("io_ld_rv_wait", {31'd0, bus.resp_valid}, 32'd0);
            step();
        end
        chk("io_ld_cmd_c4", {30'd0, bus.mem_cmd}, 32'h0);
        chk("io_ld_addr_c4", {23'd0, bus.mem_addr}, 32'h100);
        bus.io_ready = 1'b1;
        io_rdata     = 16'hBEEF;
        step();
        bus.io_ready = 1'b0;
        chk("io_ld_rv", {31'd0, bus.resp_valid}, 32'd1);
        chk("io_ld_rdata", {16'd0, bus.resp_rdata}, 32'hBEEF);
        chk("io_ld_err", {31'd0, bus.resp_err}, 32'd0);
        chk("io_ld_cmd_done", {30'd0, bus.mem_cmd}, 32'h1);
        step();

        // I/O store 1FF with no io_ready: timeout
        put_req(1'b1, 9'h1FF, 16'h1234);
        step();
        bus.req_valid = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            chk("io_to_cmd_wait", {30'd0, bus.mem_cmd}, 32'h2);
            chk("io_to_rv_wait", {31'd0, bus.resp_valid}, 32'd0);
            step();
        end
        chk("io_to_rv", {31'd0, bus.resp_valid}, 32'd1);
        chk("io_to_err", {31'd0, bus.resp_err}, 32'd1);
        chk("io_to_rdata", {16'd0, bus.resp_rdata}, 32'h0);
        chk("io_to_cmd", {30'd0, bus.mem_cmd}, 32'h1);
        step();
        chk("io_to_rv_after", {31'd0, bus.resp_valid}, 32'd0);

        // Reset during RD_DATA
        put_req(1'b0, 9'h012, 16'h0);
        step();
        bus.req_valid = 1'b0;
        step();
        reset = 1'b1;
        #1;
        chk("rrd_cmd", {30'd0, bus.mem_cmd}, 32'h1);
        chk("rrd_rv", {31'd0, bus.resp_valid}, 32'd0);
        step();
        chk("rrd_rv_next", {31'd0, bus.resp_valid}, 32'd0);
        reset = 1'b0;
        step();
        chk("rrd_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rrd_rv_after", {31'd0, bus.resp_valid}, 32'd0);

        // Reset during WR: the write must not reach the RAM
        put_req(1'b1, 9'h012, 16'hDEAD);
        step();
        bus.req_valid = 1'b0;
        chk("rwr_cmd_before", {30'd0, bus.mem_cmd}, 32'h2);
        reset = 1'b1;
        #1;
        chk("rwr_cmd", {30'd0, bus.mem_cmd}, 32'h1);
        step();
        chk("rwr_rv", {31'd0, bus.resp_valid}, 32'd0);
        chk("rwr_ram", {16'd0, ram[8'h12]}, 32'h00A5);
        reset = 1'b0;
        step();

        put_req(1'b0, 9'h012, 16'h0);
        step();
        bus.req_valid = 1'b0;
        step();
        step();
        chk("post_rst_rv", {31'd0, bus.resp_valid}, 32'd1);
        chk("post_rst_rdata", {16'd0, bus.resp_rdata}, 32'h00A5);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
